// File: rtl/mdu_sequencer_if.sv
// E-stage multiply/divide unit bus: issue side from the pipeline, status and
// HI/LO results back to the pipeline and hazard logic.
interface mdu_sequencer_if;
  logic        E_valid;
  logic [3:0]  E_MDU_op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_MDU_en;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] E_MDU_out;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_valid, E_MDU_op, E_A, E_B, D_MDU_en,
    input  start, busy, stall_md, E_MDU_out, HI, LO
  );

  modport slave (
    input  E_valid, E_MDU_op, E_A, E_B, D_MDU_en,
    output start, busy, stall_md, E_MDU_out, HI, LO
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Fixed-latency multiply/divide sequencer for the E stage. Owns HI/LO,
// computes the result at issue, holds it for N busy cycles, then commits.
//
// state | meaning
// IDLE  | no operation in flight; accepts mult/div and mthi/mtlo
// RUN   | result held in tmp_hi/tmp_lo, counter running down to commit
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  mdu_sequencer_if.slave bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          busy_q, busy_nxt;
  logic          load, done;

  logic [31:0]   hi_q, lo_q, tmp_hi, tmp_lo;
  logic          tmp_wr;

  logic          is_md, is_div, div_signed, a_neg, b_neg;
  logic [31:0]   a_mag, b_mag, divisor, q_mag, r_mag;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   res_hi, res_lo;

  assign is_md  = (bus.E_MDU_op >= OP_MULT) && (bus.E_MDU_op <= OP_DIVU);
  assign is_div = (bus.E_MDU_op == OP_DIV) || (bus.E_MDU_op == OP_DIVU);

  assign bus.start    = bus.E_valid && is_md && (state == IDLE);
  assign bus.busy     = busy_q;
  assign bus.stall_md = (bus.start || busy_q) && bus.D_MDU_en;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;

  // Read port: mfhi/mflo see the committed registers, so a same-cycle write is not visible.
  always_comb begin
    bus.E_MDU_out = 32'd0;
    if (bus.E_valid && (bus.E_MDU_op == OP_MFHI)) bus.E_MDU_out = hi_q;
    if (bus.E_valid && (bus.E_MDU_op == OP_MFLO)) bus.E_MDU_out = lo_q;
  end

  // Result datapath: products by sign/zero extension, divides on magnitudes
  // with signs restored, which also yields 0x80000000/-1 = 0x80000000 rem 0.
  always_comb begin
    prod_s     = {{32{bus.E_A[31]}}, bus.E_A} * {{32{bus.E_B[31]}}, bus.E_B};
    prod_u     = {32'd0, bus.E_A} * {32'd0, bus.E_B};
    div_signed = (bus.E_MDU_op == OP_DIV);
    a_neg      = div_signed && bus.E_A[31];
    b_neg      = div_signed && bus.E_B[31];
    a_mag      = a_neg ? (32'd0 - bus.E_A) : bus.E_A;
    b_mag      = b_neg ? (32'd0 - bus.E_B) : bus.E_B;
    divisor    = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag      = a_mag / divisor;
    r_mag      = a_mag % divisor;
    res_hi     = prod_u[63:32];
    res_lo     = prod_u[31:0];
    if (bus.E_MDU_op == OP_MULT) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end else if (is_div) begin
      res_lo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      res_hi = a_neg ? (32'd0 - r_mag) : r_mag;
    end
  end

  // FSM state, busy flag and down-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      busy_q <= busy_nxt;
    end
  end

  // Next state: load the latency on accept, commit on terminal count of 1.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    busy_nxt  = busy_q;
    load      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          busy_nxt  = 1'b1;
          load      = 1'b1;
          count_nxt = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      RUN: begin
        count_nxt = count - CW'(1);
        if (count == CW'(1)) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pending result captured at issue; divide by zero marks it as no-write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmp_hi <= 32'd0;
      tmp_lo <= 32'd0;
      tmp_wr <= 1'b0;
    end else if (load) begin
      tmp_hi <= res_hi;
      tmp_lo <= res_lo;
      tmp_wr <= !(is_div && (bus.E_B == 32'd0));
    end
  end

  // HI/LO: commit at end of RUN, or immediate mthi/mtlo while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (done) begin
      if (tmp_wr) begin
        hi_q <= tmp_hi;
        lo_q <= tmp_lo;
      end
    end else if (bus.E_valid && (state == IDLE)) begin
      if (bus.E_MDU_op == OP_MTHI) hi_q <= bus.E_A;
      if (bus.E_MDU_op == OP_MTLO) lo_q <= bus.E_A;
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed corner cases plus random
// operation streams compared against an arithmetic HI/LO model.
module tb_mdu_sequencer;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [31:0] m_hi, m_lo;

  mdu_sequencer_if bus();

  mdu_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural result of an MDU op given the old {HI,LO}.
  function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] old);
    longint sa, sb, q, r;
    logic [63:0] res;
    res = old;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      4'd1: res = sa * sb;
      4'd2: res = {32'd0, a} * {32'd0, b};
      4'd3: if (b != 32'd0) begin
              q   = sa / sb;
              r   = sa % sb;
              res = {r[31:0], q[31:0]};
            end
      4'd4: if (b != 32'd0) res = {a % b, a / b};
      default: res = old;
    endcase
    return res;
  endfunction

  task automatic set_idle();
    bus.E_valid  = 1'b0;
    bus.E_MDU_op = 4'd0;
    bus.E_A      = 32'd0;
    bus.E_B      = 32'd0;
  endtask

  // Issue a mult/div in the current cycle and follow it to completion.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic d_en, input string name);
    int n, exp_n;
    logic [63:0] r;
    bit fin;
    exp_n = (op >= 4'd3) ? DIV_N : MULT_N;
    r = ref_md(op, a, b, {m_hi, m_lo});
    bus.E_valid = 1'b1; bus.E_MDU_op = op; bus.E_A = a; bus.E_B = b; bus.D_MDU_en = d_en;
    #1;
    checks++; if (bus.start !== 1'b1) begin errors++; $display("FAIL %s start: got %b want 1", name, bus.start); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_start: got %b want 0", name, bus.busy); end
    checks++; if (bus.stall_md !== d_en) begin errors++; $display("FAIL %s stall_start: got %b want %b", name, bus.stall_md, d_en); end
    n = 0; fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      set_idle();
      #1;
      if (bus.busy === 1'b1) begin
        n++;
        checks++; if (bus.stall_md !== d_en) begin errors++; $display("FAIL %s stall_busy: got %b want %b", name, bus.stall_md, d_en); end
        // In-flight noise: any op issued during RUN must have no effect.
        bus.E_valid  = 1'($urandom);
        bus.E_MDU_op = 4'($urandom);
        bus.E_A      = $urandom;
        bus.E_B      = $urandom;
      end else begin
        fin = 1;
      end
    end
    checks++; if (!fin) begin errors++; $display("FAIL %s timeout: busy still %b want 0", name, bus.busy); end
    checks++; if (n != exp_n) begin errors++; $display("FAIL %s busy_len: got %0d want %0d", name, n, exp_n); end
    checks++; if (bus.stall_md !== 1'b0) begin errors++; $display("FAIL %s stall_after: got %b want 0", name, bus.stall_md); end
    m_hi = r[63:32];
    m_lo = r[31:0];
    checks++; if (bus.HI !== m_hi) begin errors++; $display("FAIL %s HI: got %h want %h", name, bus.HI, m_hi); end
    checks++; if (bus.LO !== m_lo) begin errors++; $display("FAIL %s LO: got %h want %h", name, bus.LO, m_lo); end
  endtask

  // Single-cycle mthi/mtlo write.
  task automatic do_mt(input logic [3:0] op, input logic [31:0] v);
    bus.E_valid = 1'b1; bus.E_MDU_op = op; bus.E_A = v; bus.E_B = $urandom;
    #1;
    checks++; if (bus.E_MDU_out !== 32'd0) begin errors++; $display("FAIL mt_out: got %h want 0", bus.E_MDU_out); end
    checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL mt_start: got %b want 0", bus.start); end
    @(negedge clk);
    set_idle();
    if (op == 4'd7) m_hi = v; else m_lo = v;
    #1;
  endtask

  // Single-cycle mfhi/mflo read, with or without a valid instruction.
  task automatic do_mf(input logic [3:0] op, input logic valid);
    logic [31:0] exp;
    exp = !valid ? 32'd0 : (op == 4'd5) ? m_hi : m_lo;
    bus.E_valid = valid; bus.E_MDU_op = op; bus.E_A = $urandom; bus.E_B = $urandom;
    #1;
    checks++; if (bus.E_MDU_out !== exp) begin errors++; $display("FAIL mf_out op%0d v%0b: got %h want %h", op, valid, bus.E_MDU_out, exp); end
    @(negedge clk);
    set_idle();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.D_MDU_en = 1'b1;
    set_idle();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.HI !== 32'd0) begin errors++; $display("FAIL reset_HI: got %h want 0", bus.HI); end
    checks++; if (bus.LO !== 32'd0) begin errors++; $display("FAIL reset_LO: got %h want 0", bus.LO); end
    checks++; if (bus.stall_md !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall_md); end
    checks++; if (bus.E_MDU_out !== 32'd0) begin errors++; $display("FAIL reset_out: got %h want 0", bus.E_MDU_out); end
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    bus.D_MDU_en = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_mult_div();
    run_op(4'd1, 32'hFFFFFFFD, 32'd5, 1'b0, "mult_neg");
    run_op(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0, "multu");
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, "div_neg");
    run_op(4'd4, 32'hFFFFFFF9, 32'd2, 1'b0, "divu");
    run_op(4'd3, 32'd7, 32'hFFFFFFFE, 1'b0, "div_negb");
  endtask

  task automatic test_stall();
    run_op(4'd1, 32'd1234, 32'd5678, 1'b1, "stall_mult");
    run_op(4'd3, 32'd100, 32'd7, 1'b1, "stall_div");
    run_op(4'd2, 32'd3, 32'd9, 1'b0, "nostall_multu");
  endtask

  task automatic test_div_corner();
    do_mt(4'd7, 32'h1234);
    do_mt(4'd8, 32'h5678);
    run_op(4'd4, 32'hDEADBEEF, 32'd0, 1'b1, "divu_zero");
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
    run_op(4'd3, 32'h11111111, 32'd0, 1'b0, "div_zero");
  endtask

  task automatic test_reset_mid_run();
    do_mt(4'd7, 32'hA5A5A5A5);
    do_mt(4'd8, 32'h5A5A5A5A);
    bus.E_valid = 1'b1; bus.E_MDU_op = 4'd3; bus.E_A = 32'd1000; bus.E_B = 32'd3;
    repeat (3) begin
      @(negedge clk);
      set_idle();
    end
    #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrun_pre_busy: got %b want 1", bus.busy); end
    reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrun_busy: got %b want 0", bus.busy); end
    checks++; if (bus.HI !== 32'd0) begin errors++; $display("FAIL midrun_HI: got %h want 0", bus.HI); end
    checks++; if (bus.LO !== 32'd0) begin errors++; $display("FAIL midrun_LO: got %h want 0", bus.LO); end
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
        errors++;
        $display("FAIL midrun_after cyc%0d: got busy=%b HI=%h LO=%h want 0/0/0", i, bus.busy, bus.HI, bus.LO);
      end
    end
  endtask

  task automatic test_move();
    do_mt(4'd7, 32'hCAFEBABE);
    do_mf(4'd5, 1'b1);
    do_mt(4'd8, 32'h0BADF00D);
    do_mf(4'd6, 1'b1);
    do_mf(4'd6, 1'b0);
    do_mf(4'd5, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op(4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, "b2b_first");
    run_op(4'd4, 32'hFFFFFFFF, 32'd10, 1'b1, "b2b_second");
    run_op(4'd2, 32'h80000000, 32'h80000000, 1'b0, "b2b_third");
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(1, 8));
      a  = $urandom;
      b  = $urandom;
      if (op >= 4'd3 && op <= 4'd4) begin
        if ($urandom_range(0, 3) == 0) b = 32'd0;
        else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 16));
      end
      if (op <= 4'd4) run_op(op, a, b, 1'($urandom), "random_md");
      else if (op <= 4'd6) do_mf(op, 1'($urandom));
      else do_mt(op, a);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_mult_div();
    test_stall();
    test_div_corner();
    test_reset_mid_run();
    test_move();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide controller for the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E and sequences a fixed-latency operation with a cycle counter.
- Owns the HI/LO registers and generates the start/busy pair that the hazard logic uses for the MDU stall.
- Also produces the stall request itself: stall_md = (start||busy) && D_MDU_en.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (must be >=1)
DIV_CYCLES, 10, busy cycles for div/divu (must be >=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
E_valid  input  1  E-stage instruction is real (not a bubble)
E_MDU_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others = none
E_A  input  32  rs operand (forwarded)
E_B  input  32  rt operand (forwarded)
D_MDU_en  input  1  D-stage instruction is any MDU op (1..8)
start  output  1  combinational; high in the cycle a mult/div is accepted
busy  output  1  registered; high while an operation is in progress
stall_md  output  1  combinational; (start||busy) && D_MDU_en
E_MDU_out  output  32  combinational; HI for mfhi, LO for mflo, else 0
HI  output  32  registered HI
LO  output  32  registered LO

Behaviour:
- Reset (reset==0, async): busy=0, HI=0, LO=0, counter=0, state IDLE, result temporaries=0. Combinational outputs follow from these values.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1.
- start = E_valid && op in {1..4} && state==IDLE.
- IDLE -> RUN on a clk edge with start:
  - Latch the result into tmpHI/tmpLO, computed from E_A/E_B in that cycle.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
- RUN, each edge: counter decrements.
- RUN, edge where counter==1:
  - HI<=tmpHI, LO<=tmpLO.
  - busy<=0, state IDLE.
  - busy is therefore high for exactly N cycles, and new HI/LO are visible in the first cycle busy is low.
- A new start is accepted in the first cycle after busy falls; no back-to-back overlap.
- mult: signed 64-bit product {HI,LO}. multu: unsigned product.
- div/divu results: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- Signed overflow: div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (E_B==0): the full DIV_CYCLES busy sequence still runs, and HI/LO are left unchanged at completion.
- mthi/mtlo:
  - Write HI/LO from E_A at the edge when E_valid && state==IDLE, with no latency.
  - If issued while busy (protocol violation; prevented by stall_md) they are ignored.
- mfhi/mflo:
  - Read the current registered HI/LO combinationally.
  - An mthi and an mfhi in the same cycle return the old value.
- E_valid==0: the op is treated as none. No start, no writes, and E_MDU_out=0.
- Reset asserted mid-RUN: aborts immediately, the pending result is discarded, and all state returns to reset values.
- E_MDU_op changes during RUN have no effect on the in-flight operation.

Test Plan:
1. mult E_A=0xFFFFFFFD (-3), E_B=5 -> start=1 one cycle; busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
2. multu E_A=0xFFFFFFFF, E_B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE. div E_A=0xFFFFFFF9 (-7), E_B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. Stall: D_MDU_en=1 during start cycle and all busy cycles -> stall_md=1 in each; D_MDU_en=0 -> stall_md=0; stall_md=0 in the first cycle after busy falls.
4. Corner divides:
   - mthi 0x1234 / mtlo 0x5678, then divu E_B=0 -> busy 10 cycles, HI=0x1234, LO=0x5678 unchanged.
   - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
5. Reset pulse (reset=0) in busy cycle 3 of a div -> busy=0, HI=LO=0 immediately; no later HI/LO update.
6. mthi E_A=0xCAFEBABE then mfhi next cycle -> E_MDU_out=0xCAFEBABE. mflo with E_valid=0 -> E_MDU_out=0.
